// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU types and constants, used here by the mantissa divider.
package fpu_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
    localparam int DIV_ITERS = 8;
    localparam logic [7:0] DBZ_QUOT_DEF = 8'hFF;
endpackage

// File: rtl/add_sub_8bit.sv
// add_sub_8bit: 8-bit adder/subtractor; aos=1 subtracts, co=1 means no borrow.
module add_sub_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       aos,
    output logic [7:0] s,
    output logic       co
);
    logic [7:0] b_eff;
    assign b_eff = aos ? ~b : b;
    assign {co, s} = {1'b0, a} + {1'b0, b_eff} + 9'(aos);
endmodule

// File: rtl/div_8bit_seq.sv
// div_8bit_seq: iterative 8-bit unsigned restoring divider, one quotient bit per cycle.
module div_8bit_seq
    import fpu_pkg::*;
#(
    parameter int         WIDTH    = 8,
    parameter logic [7:0] DBZ_QUOT = DBZ_QUOT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam logic [2:0] LAST = 3'(DIV_ITERS - 1);
    div_state_t state_q, state_d;
    logic [2:0] count_q, count_d;
    logic [7:0] d_q, d_d, q_q, q_d, quot_q, quot_d, rem_q, rem_d;
    logic [8:0] r_q, r_d, rs, r_step;
    logic [7:0] q_step, s;
    logic       co, ok, dbz_q, dbz_d, busy_q, busy_d, done_q, done_d;
    assign rs = {r_q[7:0], q_q[7]};
    add_sub_8bit u_sub (
        .a  (rs[7:0]),
        .b  (d_q),
        .aos(1'b1),
        .s  (s),
        .co (co)
    );
    // R < D holds after each step, so Rs[8] set means the subtract must succeed.
    assign ok     = rs[8] | co;
    assign r_step = ok ? {1'b0, s} : rs;
    assign q_step = {q_q[6:0], ok};
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        d_d     = d_q;
        q_d     = q_q;
        r_d     = r_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (state_q == RUN) begin
            r_d     = r_step;
            q_d     = q_step;
            count_d = count_q + 3'd1;
            busy_d  = count_q != LAST;
            done_d  = count_q == LAST;
            state_d = count_q == LAST ? DONE : RUN;
            quot_d  = count_q == LAST ? q_step : quot_q;
            rem_d   = count_q == LAST ? r_step[7:0] : rem_q;
        end else if (start && divisor == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            quot_d  = DBZ_QUOT;
            rem_d   = dividend;
            dbz_d   = 1'b1;
        end else if (start) begin
            state_d = RUN;
            busy_d  = 1'b1;
            d_d     = divisor;
            q_d     = dividend;
            r_d     = '0;
            count_d = '0;
            dbz_d   = 1'b0;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            d_q     <= d_d;
            q_q     <= q_d;
            r_q     <= r_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_8bit_seq.sv
// tb_div_8bit_seq: scoreboard bench for div_8bit_seq against reference / and %.
module tb_div_8bit_seq;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] dividend, divisor, quotient, remainder;
    logic       busy, done, div_by_zero;
    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } res_t;
    res_t sb[$];
    res_t mon_e;
    int errors = 0, checks = 0, cyc = 0, t_cyc = 0, dones = 0, d0 = 0;

    div_8bit_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [7:0] dd, input logic [7:0] dv);
        res_t m;
        if (dv == 8'd0) begin
            m.q = 8'hFF; m.r = dd; m.dbz = 1'b1;
        end else begin
            m.q = dd / dv; m.r = dd % dv; m.dbz = 1'b0;
        end
        return m;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            dones++;
            if (sb.size() == 0) check("spurious_done", 1, 0);
            else begin
                mon_e = sb.pop_front();
                check("quotient", quotient, mon_e.q);
                check("remainder", remainder, mon_e.r);
                check("div_by_zero", div_by_zero, mon_e.dbz);
            end
        end
    end

    // Called at a negedge; start is sampled by the following posedge.
    task automatic launch(input logic [7:0] dd, input logic [7:0] dv, input bit track);
        start = 1'b1; dividend = dd; divisor = dv;
        t_cyc = cyc + 1;
        if (track) sb.push_back(model(dd, dv));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input logic [7:0] dv);
        for (int i = 0; i < 30 && !done; i++) begin
            check("busy_run", busy, dv != 8'd0);
            @(negedge clk);
        end
        if (!done) check("done_timeout", 0, 1);
        else begin
            check("latency", cyc - t_cyc, dv == 8'd0 ? 0 : 8);
            check("busy_at_done", busy, 0);
        end
    endtask

    task automatic do_op(input logic [7:0] dd, input logic [7:0] dv);
        launch(dd, dv, 1'b1);
        wait_done(dv);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] a, b, last_dv;
        int n;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);
        do_op(200, 7);
        do_op(5, 9);
        do_op(255, 1);
        do_op(255, 255);
        do_op(0, 13);
        do_op(100, 0);
        repeat (2) @(negedge clk);
        check("dbz_hold", div_by_zero, 1);
        check("dbz_quot_hold", quotient, 8'hFF);
        check("dbz_busy", busy, 0);
        do_op(9, 3);
        // start re-pulsed mid-run must be ignored
        d0 = dones;
        launch(200, 7, 1'b1);
        @(negedge clk);
        check("hold_quot", quotient, 3);
        @(negedge clk);
        start = 1'b1; dividend = 50; divisor = 5;
        @(negedge clk);
        start = 1'b0;
        wait_done(7);
        repeat (12) @(negedge clk);
        check("one_done", dones - d0, 1);
        // reset mid-operation
        launch(200, 7, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_quot", quotient, 0);
        check("mid_rst_rem", remainder, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        d0 = dones;
        repeat (12) @(negedge clk);
        check("no_done_after_rst", dones - d0, 0);
        do_op(17, 4);
        // back-to-back with start held high
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(1, 255));
        start = 1'b1; dividend = a; divisor = b; last_dv = b;
        t_cyc = cyc + 1;
        sb.push_back(model(a, b));
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            n = 0;
            while (!done && n < 30) begin
                @(negedge clk);
                n++;
            end
            if (!done) begin
                check("b2b_timeout", 0, 1);
                break;
            end
            check("b2b_latency", cyc - t_cyc, last_dv == 8'd0 ? 0 : 8);
            if (k < 999) begin
                a = 8'($urandom_range(0, 255));
                b = ($urandom_range(0, 9) == 0) ? 8'd0 :
                    ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 15)) : 8'($urandom_range(1, 255));
                dividend = a; divisor = b; last_dv = b;
                t_cyc = cyc + 1;
                sb.push_back(model(a, b));
            end else start = 1'b0;
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
